bp_fe_bht_gshare: RTL and testbench

Parametrised successor to the front-end 2-bit branch history table. It holds N-bit saturating direction counters indexed by PC, optionally XORed with a speculative global history register (gshare), so bimodal and gshare are both available. After reset it sweeps the table to clear it, keeps speculative history in the FE, and repairs that history on a backend misprediction. It sits in the FE next to the BTB and feeds the next-PC logic.

---
 rtl/bp_fe_pkg.sv | 26 ++
 rtl/bp_fe_sat_counter_update.sv | 27 ++
 rtl/bp_fe_bht_gshare.sv | 163 ++++++++++++++++
 tb/tb_bp_fe_bht_gshare.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Shared front-end branch predictor types: BHT FSM states, weak-not-taken constant, pipe metadata.
// Latency: n/a (types and constants only).
// Backpressure: n/a.

`ifndef BP_FE_BHT_WEAK_NT
`define BP_FE_BHT_WEAK_NT(width_mp) ((1 << ((width_mp) - 1)) - 1)
`endif

package bp_fe_pkg;

    typedef enum logic {
        e_bht_init,
        e_bht_ready
    } bp_fe_bht_state_e;

    // Widest index/history any BHT instance may carry down the FE queue.
    localparam int bp_fe_bht_meta_idx_width_gp   = 16;
    localparam int bp_fe_bht_meta_ghist_width_gp = 16;

    // Lookup metadata carried alongside a fetch until the branch resolves.
    typedef struct packed {
        logic [bp_fe_bht_meta_idx_width_gp-1:0]   idx;
        logic [bp_fe_bht_meta_ghist_width_gp-1:0] ghist;
    } bp_fe_bht_meta_s;

endpackage

// File: rtl/bp_fe_sat_counter_update.sv
// Next value of an unsigned saturating direction counter given the resolved direction.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.

module bp_fe_sat_counter_update #(
    parameter int width_p = 2
) (
    input  logic [width_p-1:0] cnt_i,
    input  logic               taken_i,
    output logic [width_p-1:0] cnt_o
);

    // Step toward the resolved direction, holding at the rails instead of wrapping.
    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != '1) begin
                cnt_o = cnt_i + width_p'(1);
            end
        end else begin
            if (cnt_i != '0) begin
                cnt_o = cnt_i - width_p'(1);
            end
        end
    end

endmodule

// File: rtl/bp_fe_bht_gshare.sv
// Bimodal/gshare branch history table with speculative global history and mispredict repair.
// Latency: prediction one cycle after an accepted lookup; table sweep takes 2**bht_idx_width_p cycles.
// Backpressure: none; lookups and updates are dropped until init_done_o, otherwise always accepted.

module bp_fe_bht_gshare
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p   = 39,
    parameter int bht_idx_width_p = 9,
    parameter int counter_width_p = 2,
    parameter int ghist_width_p   = 4,
    parameter int use_ghist_p     = 1,
    parameter int debug_p         = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       init_done_o,

    input  logic                       r_v_i,
    input  logic [vaddr_width_p-1:0]   r_addr_i,
    output logic                       predict_v_o,
    output logic                       predict_o,
    output logic [bht_idx_width_p-1:0] r_idx_o,
    output logic [ghist_width_p-1:0]   r_ghist_o,

    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] w_idx_i,
    input  logic                       w_taken_i,
    input  logic [ghist_width_p-1:0]   w_ghist_i,
    input  logic                       w_mispredict_i
);

    localparam int els_lp = 2 ** bht_idx_width_p;
    localparam logic [counter_width_p-1:0] weak_nt_lp =
        counter_width_p'(`BP_FE_BHT_WEAK_NT(counter_width_p));

    // Parameter legality is checked at elaboration so no index is ever silently truncated.
    if (counter_width_p < 1 || counter_width_p > 4) begin : g_chk_counter_width
        $error("bp_fe_bht_gshare: counter_width_p must be in 1..4");
    end
    if (ghist_width_p < 1 || ghist_width_p > bht_idx_width_p) begin : g_chk_ghist_width
        $error("bp_fe_bht_gshare: ghist_width_p must be in 1..bht_idx_width_p");
    end
    if (vaddr_width_p <= bht_idx_width_p + 2) begin : g_chk_vaddr_width
        $error("bp_fe_bht_gshare: vaddr_width_p too narrow for the PC index");
    end
    if (debug_p != 0 && debug_p != 1) begin : g_chk_debug
        $error("bp_fe_bht_gshare: debug_p must be 0 or 1");
    end

    bp_fe_bht_state_e             state_q, state_n;
    logic [bht_idx_width_p-1:0]   init_cnt_q;
    logic [ghist_width_p-1:0]     ghist_q;
    logic [counter_width_p-1:0]   mem_q [els_lp];

    logic                         rd_v_q;
    logic [bht_idx_width_p-1:0]   rd_idx_q;
    logic [ghist_width_p-1:0]     rd_ghist_q;

    logic [bht_idx_width_p-1:0]   pc_idx;
    logic [bht_idx_width_p-1:0]   lookup_idx;
    logic                         lookup_acc;
    logic                         restore;
    logic                         upd_v;
    logic [counter_width_p-1:0]   upd_cnt;

    // PC bits outside the word-aligned index field do not affect the prediction.
    logic unused_addr;
    assign unused_addr = ^{r_addr_i[vaddr_width_p-1:bht_idx_width_p+2], r_addr_i[1:0]};

    function automatic logic [ghist_width_p-1:0] shift_in(
        input logic [ghist_width_p-1:0] hist,
        input logic                     dir
    );
        return (hist << 1) | ghist_width_p'(dir);
    endfunction

    assign init_done_o = (state_q == e_bht_ready);
    assign pc_idx      = r_addr_i[bht_idx_width_p+1:2];
    assign lookup_idx  = (use_ghist_p != 0) ? (pc_idx ^ bht_idx_width_p'(ghist_q)) : pc_idx;
    assign lookup_acc  = r_v_i & init_done_o;
    assign upd_v       = w_v_i & init_done_o;
    assign restore     = upd_v & w_mispredict_i;

    assign predict_v_o = rd_v_q;
    assign predict_o   = rd_v_q & mem_q[rd_idx_q][counter_width_p-1];
    assign r_idx_o     = rd_idx_q;
    assign r_ghist_o   = rd_ghist_q;

    bp_fe_sat_counter_update #(
        .width_p(counter_width_p)
    ) u_sat (
        .cnt_i  (mem_q[w_idx_i]),
        .taken_i(w_taken_i),
        .cnt_o  (upd_cnt)
    );

    // State register; reset always restarts the sweep.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_bht_init;
        end else begin
            state_q <= state_n;
        end
    end

    // Leave INIT once the last entry has been written.
    always_comb begin
        state_n = state_q;
        case (state_q)
            e_bht_init:  if (init_cnt_q == '1) state_n = e_bht_ready;
            e_bht_ready: state_n = e_bht_ready;
            default:     state_n = e_bht_init;
        endcase
    end

    // Sweep pointer advances one entry per INIT cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            init_cnt_q <= '0;
        end else if (state_q == e_bht_init) begin
            init_cnt_q <= init_cnt_q + bht_idx_width_p'(1);
        end
    end

    // Single write port: sweep writes during INIT, resolved-branch updates afterwards.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (state_q == e_bht_init) begin
                mem_q[init_cnt_q] <= weak_nt_lp;
            end else if (upd_v) begin
                mem_q[w_idx_i] <= upd_cnt;
            end
        end
    end

    // Capture the lookup index and pre-shift history for the prediction cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_v_q     <= 1'b0;
            rd_idx_q   <= '0;
            rd_ghist_q <= '0;
        end else begin
            rd_v_q <= lookup_acc;
            if (lookup_acc) begin
                rd_idx_q   <= lookup_idx;
                rd_ghist_q <= ghist_q;
            end
        end
    end

    // Speculative history follows predictions; a mispredict overrides with the repaired snapshot.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ghist_q <= '0;
        end else if (restore) begin
            ghist_q <= shift_in(w_ghist_i, w_taken_i);
        end else if (rd_v_q) begin
            ghist_q <= shift_in(ghist_q, predict_o);
        end
    end

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
// Scoreboard bench for two BHT configurations (gshare 2-bit, bimodal 3-bit) sharing one clock.
// Latency: expectations pushed at lookup, popped one cycle later when predict_v_o is due.
// Backpressure: n/a; the bench drives one cycle at a time.

module tb_bp_fe_bht_gshare;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rv   [2];
    logic [31:0] addr [2];
    logic        wv   [2];
    logic [3:0]  widx [2];
    logic        wt   [2];
    logic [3:0]  wg   [2];
    logic        wm   [2];

    logic        done  [2];
    logic        pv_o  [2];
    logic        pred_o[2];
    logic [3:0]  ridx  [2];
    logic [3:0]  rgh   [2];

    bp_fe_bht_gshare #(
        .vaddr_width_p(32), .bht_idx_width_p(4), .counter_width_p(2),
        .ghist_width_p(4), .use_ghist_p(1), .debug_p(0)
    ) dut_a (
        .clk_i(clk), .reset_i(rst), .init_done_o(done[0]),
        .r_v_i(rv[0]), .r_addr_i(addr[0]), .predict_v_o(pv_o[0]), .predict_o(pred_o[0]),
        .r_idx_o(ridx[0]), .r_ghist_o(rgh[0]),
        .w_v_i(wv[0]), .w_idx_i(widx[0]), .w_taken_i(wt[0]), .w_ghist_i(wg[0]),
        .w_mispredict_i(wm[0])
    );

    bp_fe_bht_gshare #(
        .vaddr_width_p(32), .bht_idx_width_p(4), .counter_width_p(3),
        .ghist_width_p(4), .use_ghist_p(0), .debug_p(0)
    ) dut_b (
        .clk_i(clk), .reset_i(rst), .init_done_o(done[1]),
        .r_v_i(rv[1]), .r_addr_i(addr[1]), .predict_v_o(pv_o[1]), .predict_o(pred_o[1]),
        .r_idx_o(ridx[1]), .r_ghist_o(rgh[1]),
        .w_v_i(wv[1]), .w_idx_i(widx[1]), .w_taken_i(wt[1]), .w_ghist_i(wg[1]),
        .w_mispredict_i(wm[1])
    );

    typedef struct {
        int idx;
        int gh;
        int pred;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state per DUT.
    int tbl [2][16];
    int gh      [2];
    bit pvm     [2];
    int ppred   [2];
    bit rdy     [2];
    int icnt    [2];
    bit rst_last[2];
    int cwm [2] = '{2, 3};
    int ugm [2] = '{1, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int shift4(input int h, input int b);
        return ((h << 1) | b) & 15;
    endfunction

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; addr[d] = '0; wv[d] = 1'b0; widx[d] = '0;
            wt[d] = 1'b0; wg[d] = '0; wm[d] = 1'b0;
        end
    endtask

    // Advance the model by one cycle using the inputs currently driven to DUT d.
    task automatic mcycle(input int d);
        exp_t e;
        bit   acc;
        int   new_gh;
        int   v;
        int   maxv;
        rst_last[d] = rst;
        if (rst) begin
            gh[d] = 0; pvm[d] = 1'b0; ppred[d] = 0; rdy[d] = 1'b0; icnt[d] = 0;
            if (d == 0) q0.delete(); else q1.delete();
            return;
        end
        acc = rv[d] & rdy[d];
        e.idx = 0; e.gh = 0; e.pred = 0;
        if (acc) begin
            e.idx = ugm[d] != 0 ? (int'(addr[d][5:2]) ^ gh[d]) : int'(addr[d][5:2]);
            e.gh  = gh[d];
        end
        if (wv[d] && wm[d] && rdy[d]) new_gh = shift4(int'(wg[d]), int'(wt[d]));
        else if (pvm[d])              new_gh = shift4(gh[d], ppred[d]);
        else                          new_gh = gh[d];
        if (wv[d] && rdy[d]) begin
            v    = tbl[d][widx[d]];
            maxv = (1 << cwm[d]) - 1;
            if (wt[d]) begin if (v < maxv) v++; end
            else       begin if (v > 0) v--; end
            tbl[d][widx[d]] = v;
        end
        if (acc) begin
            e.pred = (tbl[d][e.idx] >> (cwm[d] - 1)) & 1;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        ppred[d] = acc ? e.pred : 0;
        pvm[d]   = acc;
        gh[d]    = new_gh;
        if (!rdy[d]) begin
            icnt[d]++;
            if (icnt[d] == 16) begin
                rdy[d] = 1'b1;
                for (int i = 0; i < 16; i++) tbl[d][i] = (1 << (cwm[d] - 1)) - 1;
            end
        end
    endtask

    task automatic check_out(input int d);
        exp_t e;
        chk($sformatf("init_done%0d", d), 32'(done[d]), 32'(rdy[d]));
        chk($sformatf("predict_v%0d", d), 32'(pv_o[d]), 32'(pvm[d]));
        if (pvm[d]) begin
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk($sformatf("r_idx%0d", d),   32'(ridx[d]),   32'(e.idx));
            chk($sformatf("r_ghist%0d", d), 32'(rgh[d]),    32'(e.gh));
            chk($sformatf("predict%0d", d), 32'(pred_o[d]), 32'(e.pred));
        end
        if (rst_last[d]) begin
            chk($sformatf("rst_idx%0d", d),   32'(ridx[d]), 32'(0));
            chk($sformatf("rst_ghist%0d", d), 32'(rgh[d]),  32'(0));
        end
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++) mcycle(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check_out(d);
        idle();
    endtask

    task automatic lookup(input int d, input int pc_idx);
        rv[d]   = 1'b1;
        addr[d] = 32'(pc_idx) << 2;
    endtask

    // Choose the PC whose hashed index lands on target under the model's current history.
    task automatic lookup_to(input int d, input int target);
        lookup(d, ugm[d] != 0 ? (target ^ gh[d]) : target);
    endtask

    task automatic upd(input int d, input int idx, input bit taken);
        wv[d] = 1'b1; widx[d] = 4'(idx); wt[d] = taken;
    endtask

    task automatic restore(input int d, input int idx, input int hist, input bit taken);
        wv[d] = 1'b1; wm[d] = 1'b1; widx[d] = 4'(idx); wg[d] = 4'(hist); wt[d] = taken;
    endtask

    initial begin
        idle();
        // Reset, partial sweep with ignored traffic, reset again mid-sweep, full sweep.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            lookup(0, i); lookup(1, i); upd(0, 3, 1'b1); upd(1, 7, 1'b1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("init_low", 32'(done[0]), 32'(0));
            lookup(0, i); lookup(1, i);
            step();
        end
        chk("init_high_a", 32'(done[0]), 32'(1));
        chk("init_high_b", 32'(done[1]), 32'(1));

        // Every entry starts weak-not-taken.
        for (int i = 0; i < 16; i++) begin
            lookup(0, i); lookup(1, i);
            step();
            chk("weak_nt_a", 32'(pred_o[0]), 32'(0));
        end
        step();

        // Saturating increment then decrement at idx 3.
        for (int i = 0; i < 4; i++) begin upd(0, 3, 1'b1); step(); end
        lookup_to(0, 3);
        step();
        chk("sat_hi_pred", 32'(pred_o[0]), 32'(1));
        for (int i = 0; i < 4; i++) begin upd(0, 3, 1'b0); step(); end
        upd(0, 3, 1'b1);
        step();
        lookup_to(0, 3);
        step();
        chk("sat_lo_pred", 32'(pred_o[0]), 32'(0));
        step();
        upd(0, 3, 1'b1);
        step();
        lookup_to(0, 3);
        step();
        chk("sat_lo_up_pred", 32'(pred_o[0]), 32'(1));
        step();

        // Clear history, train idx 5 taken, check the gshare hash.
        restore(0, 15, 0, 1'b0);
        step();
        upd(0, 5, 1'b1); step();
        upd(0, 5, 1'b1); step();
        lookup(0, 5);
        step();
        chk("hash_idx0", 32'(ridx[0]), 32'(5));
        chk("hash_gh0",  32'(rgh[0]),  32'(0));
        chk("hash_pred", 32'(pred_o[0]), 32'(1));
        step();
        lookup(0, 5);
        step();
        chk("hash_idx1", 32'(ridx[0]), 32'(4));
        chk("hash_gh1",  32'(rgh[0]),  32'(1));

        // Mispredict in the prediction cycle drops the speculative shift.
        lookup(0, 9);
        step();
        restore(0, 0, 4'b1010, 1'b0);
        step();
        lookup(0, 0);
        step();
        chk("restore_gh",  32'(rgh[0]),  32'(4'b0100));
        chk("restore_idx", 32'(ridx[0]), 32'(4));
        step();

        // Update during the prediction cycle is not seen by that prediction.
        lookup_to(0, 6);
        step();
        chk("rw_old", 32'(pred_o[0]), 32'(0));
        upd(0, 6, 1'b1);
        step();
        lookup_to(0, 6);
        step();
        chk("rw_new", 32'(pred_o[0]), 32'(1));
        step();

        // Bimodal 3-bit instance: history maintained but ignored for indexing.
        restore(1, 9, 4'b1111, 1'b1);
        step();
        lookup(1, 7);
        step();
        chk("bim_idx",  32'(ridx[1]),   32'(7));
        chk("bim_gh",   32'(rgh[1]),    32'(4'b1111));
        chk("bim_init", 32'(pred_o[1]), 32'(0));
        for (int i = 0; i < 5; i++) begin
            upd(1, 7, 1'b1);
            step();
            lookup(1, 7);
            step();
            chk("bim_pred", 32'(pred_o[1]), 32'(1));
            chk("bim_idx_hold", 32'(ridx[1]), 32'(7));
        end
        for (int i = 0; i < 4; i++) begin upd(1, 7, 1'b0); step(); end
        lookup(1, 7);
        step();
        chk("bim_sat_hi", 32'(pred_o[1]), 32'(0));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
